openmips_min_sopc: RTL and testbench

- Minimal system-on-chip: a 5-stage in-order MIPS32 pipeline core (IF, ID, EX, MEM, WB) plus a combinational instruction ROM.
- Executes ORI; every other encoding behaves as a NOP.
- Resolves read-after-write hazards between back-to-back dependent instructions by forwarding, with no stalls.
- Top level of the processor bring-up environment; no external data bus.

---
 rtl/openmips_pkg.sv | 58 +++++
 rtl/openmips_if.sv | 9 +
 rtl/openmips.sv | 103 ++++++++++
 rtl/openmips_inst_rom.sv | 20 ++
 rtl/openmips_regfile.sv | 47 ++++
 rtl/openmips_min_sopc.sv | 27 ++
 tb/tb_openmips_min_sopc.sv | 234 +++++++++++++++++++++++
 7 files changed

// File: rtl/openmips_pkg.sv
// Shared constants, encodings and stage-record types for the minimal MIPS SoC.
package openmips_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  localparam int ROM_DEPTH_DEFAULT  = 1024;
  localparam int ROM_ADDR_W_DEFAULT = 10;

  localparam logic [5:0]            OP_ORI       = 6'b001101;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = 5'd0;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [7:0] {
    ALUOP_NOP = 8'b0000_0000,
    ALUOP_OR  = 8'b0010_0101
  } aluop_e;

  typedef enum logic [2:0] {
    ALUSEL_NOP   = 3'b000,
    ALUSEL_LOGIC = 3'b001
  } alusel_e;

  // Decoded instruction travelling from ID into EX.
  typedef struct packed {
    aluop_e    aluop;
    alusel_e   alusel;
    word_t     reg1;
    word_t     reg2;
    reg_addr_t wd;
    logic      wreg;
  } id_ex_t;

  // Register write-back record carried through EX/MEM and MEM/WB.
  typedef struct packed {
    reg_addr_t wd;
    logic      wreg;
    word_t     wdata;
  } wb_t;

  localparam id_ex_t ID_EX_NOP = '{aluop: ALUOP_NOP, alusel: ALUSEL_NOP,
                                   reg1: '0, reg2: '0,
                                   wd: NOP_REG_ADDR, wreg: 1'b0};
  localparam wb_t    WB_NOP    = '{wd: NOP_REG_ADDR, wreg: 1'b0, wdata: '0};

  // Source operand selection: newest producer wins, $0 is always zero.
  function automatic word_t fwd_operand(reg_addr_t src, wb_t ex_res, wb_t mem_res,
                                        word_t rf_data);
    if (src == NOP_REG_ADDR)                  return '0;
    else if (ex_res.wreg && ex_res.wd == src)   return ex_res.wdata;
    else if (mem_res.wreg && mem_res.wd == src) return mem_res.wdata;
    else                                      return rf_data;
  endfunction

endpackage

// File: rtl/openmips_if.sv
// Instruction-fetch bus between the core (master) and the instruction ROM (slave).
interface openmips_if;
  logic        ce;
  logic [31:0] addr;
  logic [31:0] data;

  modport master (output ce, output addr, input  data);
  modport slave  (input  ce, input  addr, output data);
endinterface

// File: rtl/openmips.sv
// Five-stage MIPS32 pipeline core executing ORI, with EX/MEM operand forwarding in ID.
module openmips
  import openmips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rom_data_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o
);

  word_t  pc_q;
  logic   ce_q;
  word_t  if_id_inst_q;
  id_ex_t id_ex_d, id_ex_q;
  wb_t    ex_out, ex_mem_q, mem_wb_q;
  word_t  rf_rdata1, rf_rdata2;

  // Fetch: first edge after reset enables the ROM, later edges step the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q <= 1'b0;
      pc_q <= '0;
    end else begin
      ce_q <= 1'b1;
      if (ce_q) pc_q <= pc_q + 32'd4;
    end
  end

  assign rom_addr_o = pc_q;
  assign rom_ce_o   = ce_q;

  // IF/ID latch; the ROM already returns zero (a NOP) while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) if_id_inst_q <= '0;
    else      if_id_inst_q <= rom_data_i;
  end

  logic [5:0] id_op;
  reg_addr_t  id_rs, id_rt;
  logic [15:0] id_imm;
  assign id_op  = if_id_inst_q[31:26];
  assign id_rs  = if_id_inst_q[25:21];
  assign id_rt  = if_id_inst_q[20:16];
  assign id_imm = if_id_inst_q[15:0];

  // Decode: ORI becomes an OR with the zero-extended immediate, anything else a NOP.
  always_comb begin
    id_ex_d = ID_EX_NOP;
    if (id_op == OP_ORI) begin
      id_ex_d.aluop  = ALUOP_OR;
      id_ex_d.alusel = ALUSEL_LOGIC;
      id_ex_d.reg1   = fwd_operand(id_rs, ex_out, ex_mem_q, rf_rdata1);
      id_ex_d.reg2   = {16'h0000, id_imm};
      id_ex_d.wd     = id_rt;
      id_ex_d.wreg   = 1'b1;
    end
  end

  // ID/EX latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) id_ex_q <= ID_EX_NOP;
    else      id_ex_q <= id_ex_d;
  end

  // Execute: logic unit, only OR is implemented.
  always_comb begin
    ex_out       = WB_NOP;
    ex_out.wd    = id_ex_q.wd;
    ex_out.wreg  = id_ex_q.wreg;
    if (id_ex_q.alusel == ALUSEL_LOGIC && id_ex_q.aluop == ALUOP_OR)
      ex_out.wdata = id_ex_q.reg1 | id_ex_q.reg2;
  end

  // EX/MEM latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ex_mem_q <= WB_NOP;
    else      ex_mem_q <= ex_out;
  end

  // MEM/WB latch; the MEM stage has no data access so it passes the record straight on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem_wb_q <= WB_NOP;
    else      mem_wb_q <= ex_mem_q;
  end

  openmips_regfile regfile1 (
    .clk      (clk),
    .rst      (rst),
    .we_i     (mem_wb_q.wreg),
    .waddr_i  (mem_wb_q.wd),
    .wdata_i  (mem_wb_q.wdata),
    .raddr1_i (id_rs),
    .rdata1_o (rf_rdata1),
    .raddr2_i (id_rt),
    .rdata2_o (rf_rdata2)
  );

  // ORI never reads rt; the second port is kept for future R-type decode.
  logic unused_rdata2;
  assign unused_rdata2 = ^rf_rdata2;

endmodule

// File: rtl/openmips_inst_rom.sv
// Combinational instruction ROM; contents are preloaded through inst_mem.
module openmips_inst_rom #(
  parameter int INST_MEM_NUM    = openmips_pkg::ROM_DEPTH_DEFAULT,
  parameter int INST_MEM_ADDR_W = openmips_pkg::ROM_ADDR_W_DEFAULT
) (
  openmips_if.slave bus
);

  logic [31:0] inst_mem [0:INST_MEM_NUM-1];

  // Word-indexed lookup; upper address bits are dropped so fetch wraps at the ROM depth.
  always_comb begin
    bus.data = '0;
    if (bus.ce) bus.data = inst_mem[bus.addr[INST_MEM_ADDR_W+1:2]];
  end

  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:INST_MEM_ADDR_W+2], bus.addr[1:0]};

endmodule

// File: rtl/openmips_regfile.sv
// 32 x 32 register file: two combinational read ports with write bypass, one write port.
module openmips_regfile
  import openmips_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we_i,
  input  reg_addr_t waddr_i,
  input  word_t     wdata_i,
  input  reg_addr_t raddr1_i,
  output word_t     rdata1_o,
  input  reg_addr_t raddr2_i,
  output word_t     rdata2_o
);

  word_t regs [0:REG_NUM-1];

  // Synchronous write, $0 is never written; async reset clears the whole file.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we_i && waddr_i != NOP_REG_ADDR) begin
      regs[waddr_i] <= wdata_i;
    end
  end

  reg_addr_t raddr [2];
  word_t     rdata [2];

  assign raddr[0] = raddr1_i;
  assign raddr[1] = raddr2_i;
  assign rdata1_o = rdata[0];
  assign rdata2_o = rdata[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rport
      // Read port: $0 reads zero, a same-cycle write to the address is passed through.
      always_comb begin
        rdata[gi] = '0;
        if (raddr[gi] == NOP_REG_ADDR)                rdata[gi] = '0;
        else if (we_i && waddr_i == raddr[gi])        rdata[gi] = wdata_i;
        else                                          rdata[gi] = regs[raddr[gi]];
      end
    end
  endgenerate

endmodule

// File: rtl/openmips_min_sopc.sv
// Minimal SoC: pipeline core plus combinational instruction ROM on a shared fetch bus.
module openmips_min_sopc #(
  parameter int INST_MEM_NUM    = openmips_pkg::ROM_DEPTH_DEFAULT,
  parameter int INST_MEM_ADDR_W = openmips_pkg::ROM_ADDR_W_DEFAULT
) (
  input logic clk,
  input logic rst
);

  openmips_if rom_bus ();

  openmips openmips0 (
    .clk        (clk),
    .rst        (rst),
    .rom_data_i (rom_bus.data),
    .rom_addr_o (rom_bus.addr),
    .rom_ce_o   (rom_bus.ce)
  );

  openmips_inst_rom #(
    .INST_MEM_NUM    (INST_MEM_NUM),
    .INST_MEM_ADDR_W (INST_MEM_ADDR_W)
  ) inst_rom0 (
    .bus (rom_bus.slave)
  );

endmodule

// File: tb/tb_openmips_min_sopc.sv
// Scoreboard bench for openmips_min_sopc: expected register writes are queued per program,
// a monitor thread checks each write-back as it appears.
module tb_openmips_min_sopc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  openmips_min_sopc dut (
    .clk (clk),
    .rst (rst)
  );

  openmips_if mon_bus ();
  assign mon_bus.ce   = dut.openmips0.rom_ce_o;
  assign mon_bus.addr = dut.openmips0.rom_addr_o;
  assign mon_bus.data = dut.openmips0.rom_data_i;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  // Edges counted from reset release: first rising edge after release is edge 1.
  always @(posedge clk) begin
    if (!rst) edge_cnt <= 0;
    else      edge_cnt <= edge_cnt + 1;
  end

  typedef struct {
    int          edge_n;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  function automatic logic [31:0] ori(input int rs, input int rt, input logic [15:0] imm);
    return {6'b001101, rs[4:0], rt[4:0], imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end else begin
      $display("ok   %s: %08h", nm, act);
    end
  endtask

  function automatic logic [31:0] regs_or_except(input int skip);
    logic [31:0] acc = '0;
    for (int i = 0; i < 32; i++)
      if (i != skip) acc |= dut.openmips0.regfile1.regs[i];
    return acc;
  endfunction

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && dut.openmips0.regfile1.we_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_wb: got r%0d=%08h expected no write",
                   dut.openmips0.regfile1.waddr_i, dut.openmips0.regfile1.wdata_i);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wb_edge", 32'(edge_cnt + 1), 32'(e.edge_n));
          chk("wb_addr", 32'(dut.openmips0.regfile1.waddr_i), 32'(e.addr));
          chk("wb_data", dut.openmips0.regfile1.wdata_i, e.data);
        end
      end
    end
  endtask

  task automatic expect_wr(input int e, input int a, input logic [31:0] d);
    wr_t w;
    w.edge_n = e;
    w.addr   = a[4:0];
    w.data   = d;
    exp_q.push_back(w);
  endtask

  task automatic load_rom(input logic [31:0] prog[$]);
    for (int i = 0; i < 1024; i++) dut.inst_rom0.inst_mem[i] = 32'h0;
    for (int i = 0; i < prog.size(); i++) dut.inst_rom0.inst_mem[i] = prog[i];
  endtask

  task automatic reset_load(input logic [31:0] prog[$]);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    load_rom(prog);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    chk(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic expect_fwd_prog();
    expect_wr(6, 2, 32'h1);
    expect_wr(7, 3, 32'h2);
    expect_wr(8, 4, 32'h3);
    expect_wr(9, 5, 32'h1100);
    expect_wr(10, 5, 32'h1120);
    expect_wr(11, 5, 32'h5520);
    expect_wr(12, 5, 32'h5564);
  endtask

  initial begin
    logic [31:0] p_a[$];
    logic [31:0] p_b[$];
    logic [31:0] p_c[$];
    logic [31:0] p_d[$];
    logic [31:0] r5_exp [4];

    p_a.push_back(ori(0, 1, 16'h1100));

    p_b.push_back(ori(0, 2, 16'h0001));
    p_b.push_back(ori(0, 3, 16'h0002));
    p_b.push_back(ori(0, 4, 16'h0003));
    p_b.push_back(ori(0, 5, 16'h1100));
    p_b.push_back(ori(5, 5, 16'h0020));
    p_b.push_back(ori(5, 5, 16'h4400));
    p_b.push_back(ori(5, 5, 16'h0044));

    p_c.push_back(ori(0, 6, 16'h00F0));
    p_c.push_back(32'h0);
    p_c.push_back(ori(6, 7, 16'h000F));

    p_d.push_back(ori(0, 0, 16'hFFFF));
    p_d.push_back(ori(0, 8, 16'h0001));

    r5_exp[0] = 32'h1100;
    r5_exp[1] = 32'h1120;
    r5_exp[2] = 32'h5520;
    r5_exp[3] = 32'h5564;

    fork
      monitor();
    join_none

    // Reset hold, then a single independent ORI.
    repeat (10) @(negedge clk);
    load_rom(p_a);
    chk("reset_regs", regs_or_except(-1), 32'h0);
    chk("reset_pc", mon_bus.addr, 32'h0);
    chk("reset_ce", 32'(mon_bus.ce), 32'h0);
    expect_wr(6, 1, 32'h1100);
    release_rst();
    run_edges(1);
    chk("edge1_ce", 32'(mon_bus.ce), 32'h1);
    chk("edge1_pc", mon_bus.addr, 32'h0);
    run_edges(1);
    chk("edge2_pc", mon_bus.addr, 32'h4);
    run_edges(18);
    chk("indep_r1", dut.openmips0.regfile1.regs[1], 32'h00001100);
    chk("indep_others", regs_or_except(1), 32'h0);
    drain("indep_pending");

    // Back-to-back dependent ORIs forwarded from EX.
    reset_load(p_b);
    expect_fwd_prog();
    release_rst();
    run_edges(8);
    chk("fwd_r2", dut.openmips0.regfile1.regs[2], 32'h1);
    chk("fwd_r3", dut.openmips0.regfile1.regs[3], 32'h2);
    chk("fwd_r4", dut.openmips0.regfile1.regs[4], 32'h3);
    for (int e = 0; e < 4; e++) begin
      run_edges(1);
      chk($sformatf("fwd_r5_edge%0d", 9 + e), dut.openmips0.regfile1.regs[5], r5_exp[e]);
    end
    run_edges(4);
    drain("fwd_pending");

    // Forwarding from the MEM stage across a NOP.
    reset_load(p_c);
    expect_wr(6, 6, 32'h00F0);
    expect_wr(8, 7, 32'h00FF);
    release_rst();
    run_edges(12);
    chk("memfwd_r6", dut.openmips0.regfile1.regs[6], 32'h000000F0);
    chk("memfwd_r7", dut.openmips0.regfile1.regs[7], 32'h000000FF);
    drain("memfwd_pending");

    // Writes to $0 are dropped and $0 always reads as zero.
    reset_load(p_d);
    expect_wr(6, 0, 32'hFFFF);
    expect_wr(7, 8, 32'h0001);
    release_rst();
    run_edges(12);
    chk("r0_zero", dut.openmips0.regfile1.regs[0], 32'h0);
    chk("r0_r8", dut.openmips0.regfile1.regs[8], 32'h1);
    drain("r0_pending");

    // Mid-run reset after edge 7, then a full rerun from PC 0.
    reset_load(p_b);
    expect_wr(6, 2, 32'h1);
    expect_wr(7, 3, 32'h2);
    release_rst();
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_regs", regs_or_except(-1), 32'h0);
    chk("midrst_pc", mon_bus.addr, 32'h0);
    chk("midrst_ce", 32'(mon_bus.ce), 32'h0);
    drain("midrst_pending");
    expect_fwd_prog();
    release_rst();
    run_edges(14);
    chk("rerun_r5", dut.openmips0.regfile1.regs[5], 32'h00005564);
    chk("rerun_r4", dut.openmips0.regfile1.regs[4], 32'h00000003);
    drain("rerun_pending");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
